// File: rtl/set_assoc_dcache_pkg.sv
// set_assoc_dcache_pkg: FSM state encoding and derived width helpers for the data cache
package set_assoc_dcache_pkg;
  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
  localparam int ADDR_W = 32;
  localparam int BYTE_OFF_W = 2;
  function automatic int tag_w(input int line_len, input int set_len);
    return ADDR_W - BYTE_OFF_W - line_len - set_len;
  endfunction
  function automatic int line_w(input int line_len);
    return 32 * (1 << line_len);
  endfunction
  function automatic int way_w(input int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/set_assoc_dcache_lru.sv
// cache_lru: per-set recency matrix giving the least-recently-used way of a set
module cache_lru
  import set_assoc_dcache_pkg::*;
#(
  parameter int SET_ADDR_LEN = 4,
  parameter int WAY_CNT = 4,
  localparam int WW = way_w(WAY_CNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SET_ADDR_LEN-1:0] set,
  input  logic [WW-1:0]           way,
  input  logic                    touch,
  output logic [WW-1:0]           victim
);
  generate
    if (WAY_CNT == 1) begin : g_dm
      logic unused;
      assign unused = clk ^ rst ^ (^set) ^ (^way) ^ touch;
      assign victim = '0;
    end else begin : g_lru
      logic [WAY_CNT-1:0] mru_q [1<<SET_ADDR_LEN][WAY_CNT];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < (1 << SET_ADDR_LEN); s++)
            for (int i = 0; i < WAY_CNT; i++) mru_q[s][i] <= '0;
        end else if (touch) begin
          for (int i = 0; i < WAY_CNT; i++)
            if (WW'(i) == way) mru_q[set][i] <= ~(WAY_CNT'(1) << i);
            else mru_q[set][i][way] <= 1'b0;
        end
      end
      always_comb begin
        victim = '0;
        for (int i = WAY_CNT - 1; i >= 0; i--)
          if (mru_q[set][i] == '0) victim = WW'(i);
      end
    end
  endgenerate
endmodule

// File: rtl/set_assoc_dcache.sv
// set_assoc_dcache: write-back set-associative data cache with LRU replacement and line refill FSM
module set_assoc_dcache
  import set_assoc_dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN = 4,
  parameter int WAY_CNT = 4,
  localparam int TAG_W = tag_w(LINE_ADDR_LEN, SET_ADDR_LEN),
  localparam int LW = line_w(LINE_ADDR_LEN),
  localparam int WW = way_w(WAY_CNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [31:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  output logic [31:0]   rd_data,
  output logic          miss,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [LW-1:0] mem_wdata,
  input  logic [LW-1:0] mem_rdata,
  input  logic          mem_gnt,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);
  localparam int WORDS = 1 << LINE_ADDR_LEN;
  localparam int SETS = 1 << SET_ADDR_LEN;
  state_t state, next;
  logic [TAG_W-1:0] tag_q [SETS][WAY_CNT];
  logic [WAY_CNT-1:0] valid_q [SETS];
  logic [WAY_CNT-1:0] dirty_q [SETS];
  logic [31:0] data_q [SETS][WAY_CNT][WORDS];
  logic [TAG_W-1:0] req_tag_q, tag;
  logic [SET_ADDR_LEN-1:0] req_set_q, set, lru_set;
  logic [LINE_ADDR_LEN-1:0] off;
  logic [WW-1:0] victim_q, hit_way, inv_way, lru_victim, victim, lru_way;
  logic [LW-1:0] line_q;
  logic replay_q, req, match, inv_any, hit, detect, victim_dirty, install, unused;
  assign unused = ^addr[1:0];
  assign tag = addr[31 -: TAG_W];
  assign set = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign off = addr[2 +: LINE_ADDR_LEN];
  assign req = rd_req | wr_req;
  always_comb begin
    match = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int i = 0; i < WAY_CNT; i++)
      if (valid_q[set][i] && tag_q[set][i] == tag) begin
        match = 1'b1;
        hit_way = WW'(i);
      end
    for (int i = WAY_CNT - 1; i >= 0; i--)
      if (!valid_q[set][i]) begin
        inv_any = 1'b1;
        inv_way = WW'(i);
      end
  end
  assign victim = inv_any ? inv_way : lru_victim;
  assign victim_dirty = valid_q[set][victim] && dirty_q[set][victim];
  assign hit = state == IDLE && req && match;
  assign detect = state == IDLE && req && !match;
  assign install = state == SWAP_IN_OK;
  assign miss = detect || state != IDLE;
  assign rd_data = state == IDLE && match ? data_q[set][hit_way][off] : '0;
  assign mem_req = state == SWAP_OUT || state == SWAP_IN;
  assign mem_we = state == SWAP_OUT;
  assign mem_addr = state == SWAP_OUT ? {tag_q[req_set_q][victim_q], req_set_q, {(LINE_ADDR_LEN+2){1'b0}}} :
                    state == SWAP_IN  ? {req_tag_q, req_set_q, {(LINE_ADDR_LEN+2){1'b0}}} : '0;
  always_comb begin
    mem_wdata = '0;
    if (state == SWAP_OUT)
      for (int w = 0; w < WORDS; w++) mem_wdata[32*w +: 32] = data_q[req_set_q][victim_q][w];
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (detect) next = victim_dirty ? SWAP_OUT : SWAP_IN;
      SWAP_OUT: if (mem_gnt) next = SWAP_IN;
      SWAP_IN:  if (mem_gnt) next = SWAP_IN_OK;
      default:  next = IDLE;
    endcase
  end
  assign lru_set = state == IDLE ? set : req_set_q;
  assign lru_way = state == IDLE ? hit_way : victim_q;
  cache_lru #(.SET_ADDR_LEN(SET_ADDR_LEN), .WAY_CNT(WAY_CNT)) u_lru (
    .clk(clk),
    .rst(rst),
    .set(lru_set),
    .way(lru_way),
    .touch(hit || install),
    .victim(lru_victim)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      hit_cnt <= '0;
      miss_cnt <= '0;
      replay_q <= 1'b0;
    end else begin
      state <= next;
      replay_q <= install;
      if (hit && !replay_q) hit_cnt <= hit_cnt + 32'd1;
      if (detect) miss_cnt <= miss_cnt + 32'd1;
      if (hit && wr_req) dirty_q[set][hit_way] <= 1'b1;
      if (install) begin
        valid_q[req_set_q][victim_q] <= 1'b1;
        dirty_q[req_set_q][victim_q] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (detect) begin
      req_tag_q <= tag;
      req_set_q <= set;
      victim_q <= victim;
    end
    if (state == SWAP_IN && mem_gnt) line_q <= mem_rdata;
    if (hit && wr_req)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_q[set][hit_way][off][8*b +: 8] <= wr_data[8*b +: 8];
    if (install) begin
      tag_q[req_set_q][victim_q] <= req_tag_q;
      for (int w = 0; w < WORDS; w++) data_q[req_set_q][victim_q][w] <= line_q[32*w +: 32];
    end
  end
endmodule
